// File: rtl/fft_stage_sequencer.sv
// Address sequencer for an in-place radix-2 DIT FFT: walks every stage and butterfly,
// presenting RAM A/B and twiddle addresses to the datapath over a valid/ready handshake.
module fft_stage_sequencer #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bf_ready,
    input  logic                  pipe_idle,
    output logic                  busy,
    output logic                  bf_valid,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [ADDR_WIDTH-1:0] tw_addr,
    output logic [3:0]            stage,
    output logic                  done
);

    localparam int              BW     = ADDR_WIDTH - 1;
    localparam logic [BW-1:0]   B_LAST = '1;
    localparam logic [3:0]      S_LAST = 4'(ADDR_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         b_q, b_d;
    logic [3:0]            stage_q, stage_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [ADDR_WIDTH-1:0] tw_q, tw_d;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            b_q      <= '0;
            stage_q  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            stage_q  <= stage_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        stage_d = stage_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    b_d     = '0;
                    stage_d = '0;
                end
            end
            RUN: begin
                if (bf_ready) begin
                    if (b_q == B_LAST) state_d = DRAIN;
                    else               b_d     = b_q + BW'(1);
                end
            end
            DRAIN: begin
                if (pipe_idle) begin
                    if (stage_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 4'd1;
                        b_d     = '0;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are precomputed from next-state values so every port is a flop.
    // addr_a inserts a zero bit at position s into b; pos is the low s bits of b.
    always_comb begin
        b_ext    = {1'b0, b_d};
        mask     = (ADDR_WIDTH'(1) << stage_d) - ADDR_WIDTH'(1);
        addr_a_d = ((b_ext & ~mask) << 1) | (b_ext & mask);
        addr_b_d = addr_a_d + (mask + ADDR_WIDTH'(1));
        tw_d     = (b_ext & mask) << (S_LAST - stage_d);
        valid_d  = (state_d == RUN);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    assign busy     = busy_q;
    assign bf_valid = valid_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign tw_addr  = tw_q;
    assign stage    = stage_q;
    assign done     = done_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (512-point): cycle-exact timing, address model,
// backpressure, drain hold, ignored start pulses and mid-transform reset.
module tb_fft_stage_sequencer;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bf_ready;
    logic          pipe_idle;
    logic          busy;
    logic          bf_valid;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] tw_addr;
    logic [3:0]    stage;
    logic          done;

    int checks = 0;
    int fails  = 0;

    fft_stage_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bf_ready  (bf_ready),
        .pipe_idle (pipe_idle),
        .busy      (busy),
        .bf_valid  (bf_valid),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .tw_addr   (tw_addr),
        .stage     (stage),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference address model written directly from grp/pos/span arithmetic.
    function automatic int ref_a(input int s, input int b);
        int span = 1 << s;
        int grp  = b >> s;
        int pos  = b & (span - 1);
        return (grp << (s + 1)) | pos;
    endfunction

    function automatic int ref_b(input int s, input int b);
        return ref_a(s, b) + (1 << s);
    endfunction

    function automatic int ref_tw(input int s, input int b);
        int pos = b & ((1 << s) - 1);
        return pos << (AW - 1 - s);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        tick;
        tick;
        checks++;
        if ({busy, bf_valid, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: busy/valid/done=%b want 000", {busy, bf_valid, done});
        end
        checks++;
        if (addr_a !== '0 || addr_b !== '0 || tw_addr !== '0 || stage !== 4'd0) begin
            fails++;
            $display("FAIL reset_addr: a=%0d b=%0d tw=%0d s=%0d want all 0", addr_a, addr_b, tw_addr, stage);
        end
        rst = 1'b0;
        start = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    // Start at cycle 0, bf_ready=pipe_idle=1; optional extra start pulses while busy.
    task automatic test_full_run(input bit inject);
        int  xfers = 0;
        int  k, r;
        bit  ev;
        bf_ready  = 1'b1;
        pipe_idle = 1'b1;
        start     = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 2315; c++) begin
            k  = (c - 1) / 257;
            r  = (c - 1) % 257;
            ev = (c <= 2313) && (r < 256);
            checks++;
            if (bf_valid !== ev) begin
                fails++;
                $display("FAIL run_valid c=%0d: got %b want %b", c, bf_valid, ev);
            end
            checks++;
            if (done !== (c == 2314)) begin
                fails++;
                $display("FAIL run_done c=%0d: got %b want %b", c, done, (c == 2314));
            end
            checks++;
            if (busy !== (c <= 2314)) begin
                fails++;
                $display("FAIL run_busy c=%0d: got %b want %b", c, busy, (c <= 2314));
            end
            if (bf_valid === 1'b1) xfers++;
            if (ev) begin
                checks++;
                if (stage !== 4'(k) || addr_a !== AW'(ref_a(k, r)) || addr_b !== AW'(ref_b(k, r))
                    || tw_addr !== AW'(ref_tw(k, r))) begin
                    fails++;
                    $display("FAIL run_addr s=%0d b=%0d: got s=%0d a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                             k, r, stage, addr_a, addr_b, tw_addr, ref_a(k, r), ref_b(k, r), ref_tw(k, r));
                end
                if ((k == 0 && r == 1) || (k == 1 && r == 1) || (k == 8 && r == 255)) begin
                    checks++;
                    if ((k == 0 && {addr_a, addr_b, tw_addr} !== {9'd2, 9'd3, 9'd0}) ||
                        (k == 1 && {addr_a, addr_b, tw_addr} !== {9'd1, 9'd3, 9'd128}) ||
                        (k == 8 && {addr_a, addr_b, tw_addr} !== {9'd255, 9'd511, 9'd255})) begin
                        fails++;
                        $display("FAIL spot_addr s=%0d b=%0d: got a=%0d b=%0d tw=%0d", k, r, addr_a, addr_b, tw_addr);
                    end
                end
            end
            start = inject && (c == 5 || c == 700 || c == 2313 || c == 2314);
            if (c != 2315) tick;
        end
        start = 1'b0;
        checks++;
        if (xfers != 2304) begin
            fails++;
            $display("FAIL run_xfers: got %0d want 2304", xfers);
        end
    endtask

    task automatic test_backpressure;
        int  cnt [512];
        int  exp_s = 0, exp_b = 0, xfers = 0, bad;
        bit  finished = 0, stalled = 0;
        logic [AW-1:0] pa, pb, pt;
        foreach (cnt[i]) cnt[i] = 0;
        pipe_idle = 1'b1;
        bf_ready  = 1'b0;
        start     = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 20000 && !finished; c++) begin
            if (done === 1'b1) begin
                finished = 1;
            end else if (bf_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (addr_a !== pa || addr_b !== pb || tw_addr !== pt) begin
                        fails++;
                        $display("FAIL bp_stable: a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                                 addr_a, addr_b, tw_addr, pa, pb, pt);
                    end
                end
                checks++;
                if (stage !== 4'(exp_s) || addr_a !== AW'(ref_a(exp_s, exp_b)) ||
                    addr_b !== AW'(ref_b(exp_s, exp_b)) || tw_addr !== AW'(ref_tw(exp_s, exp_b))) begin
                    fails++;
                    $display("FAIL bp_addr s=%0d b=%0d: got s=%0d a=%0d b=%0d tw=%0d", exp_s, exp_b,
                             stage, addr_a, addr_b, tw_addr);
                end
                bf_ready = ($urandom_range(0, 3) != 0);
                stalled  = !bf_ready;
                {pa, pb, pt} = {addr_a, addr_b, tw_addr};
                if (bf_ready) begin
                    cnt[addr_a]++;
                    cnt[addr_b]++;
                    xfers++;
                    exp_b++;
                    if (exp_b == 256) begin
                        bad = 0;
                        foreach (cnt[i]) begin
                            if (cnt[i] != 1) bad++;
                            cnt[i] = 0;
                        end
                        checks++;
                        if (bad != 0) begin
                            fails++;
                            $display("FAIL bp_touch stage=%0d: %0d addresses not touched exactly once", exp_s, bad);
                        end
                        exp_b = 0;
                        exp_s++;
                    end
                end
            end else begin
                bf_ready = $urandom_range(0, 1);
            end
            if (!finished) tick;
        end
        checks++;
        if (!finished || xfers != 2304 || exp_s != 9) begin
            fails++;
            $display("FAIL bp_total: finished=%0d xfers=%0d stages=%0d want 1/2304/9", finished, xfers, exp_s);
        end
        bf_ready = 1'b1;
        tick;
    endtask

    task automatic test_drain_hold;
        int exp_s = 0, dlen = 0, drains = 0;
        bit finished = 0;
        bf_ready  = 1'b1;
        pipe_idle = 1'b0;
        start     = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 5000 && !finished; c++) begin
            if (done === 1'b1) begin
                finished = 1;
                checks++;
                if (dlen != 10 || exp_s != 8) begin
                    fails++;
                    $display("FAIL drain_last: len=%0d stage=%0d want 10/8", dlen, exp_s);
                end
            end else if (bf_valid === 1'b1) begin
                if (dlen != 0) begin
                    checks++;
                    if (dlen != 10) begin
                        fails++;
                        $display("FAIL drain_len stage=%0d: got %0d want 10", exp_s, dlen);
                    end
                    exp_s++;
                    dlen = 0;
                    checks++;
                    if (stage !== 4'(exp_s) || addr_a !== '0 || addr_b !== AW'(1 << exp_s) || tw_addr !== '0) begin
                        fails++;
                        $display("FAIL drain_next: s=%0d a=%0d b=%0d tw=%0d want s=%0d a=0 b=%0d tw=0",
                                 stage, addr_a, addr_b, tw_addr, exp_s, 1 << exp_s);
                    end
                end
                pipe_idle = 1'b0;
            end else begin
                dlen++;
                if (dlen == 1) drains++;
                checks++;
                if (stage !== 4'(exp_s) || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL drain_hold: stage=%0d busy=%b want %0d/1", stage, busy, exp_s);
                end
                pipe_idle = (dlen == 10);
            end
            if (!finished) tick;
        end
        checks++;
        if (!finished || drains != 9) begin
            fails++;
            $display("FAIL drain_count: finished=%0d drains=%0d want 1/9", finished, drains);
        end
        pipe_idle = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        bf_ready  = 1'b1;
        pipe_idle = 1'b1;
        start     = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            if (bf_valid === 1'b1 && stage === 4'd3) found = 1;
            else tick;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL mid_reach: stage 3 not reached, stage=%0d", stage);
        end
        repeat (100) tick;
        bf_ready = 1'b0;
        tick;
        rst   = 1'b1;
        start = 1'b1;
        tick;
        checks++;
        if ({busy, bf_valid, done} !== 3'b000 || addr_a !== '0 || addr_b !== '0 ||
            tw_addr !== '0 || stage !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: busy=%b v=%b d=%b a=%0d b=%0d tw=%0d s=%0d want all 0",
                     busy, bf_valid, done, addr_a, addr_b, tw_addr, stage);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || bf_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_idle: busy=%b valid=%b want 0/0", busy, bf_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bf_ready  = 1'b0;
        pipe_idle = 1'b0;
        test_reset;
        test_full_run(1'b0);
        test_backpressure;
        test_drain_hold;
        test_full_run(1'b1);
        test_reset_mid;
        test_full_run(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
